// File: rtl/bram_dwc_seq_if.sv
// -----------------------------------------------------------------------------
// bram_dwc_seq_if
// Bus bundle for the sequential BRAM data width converter. It carries both the
// wide master-side request/response channel and the narrow BRAM slave port.
//
// Modports:
//   slave  : the converter itself (answers the wide master and drives the
//            narrow BRAM port)
//   master : the surrounding environment (wide master plus the BRAM macro)
//
// Signals:
//   MstReq_S/MstGnt_S        request handshake, accept on MstReq_S & MstGnt_S
//   MstAddr_S                master byte address
//   MstWe_S                  1 = write, 0 = read
//   MstBe_S/MstWr_D          master byte enables / write data
//   MstRVal_S/MstRd_D        one-cycle read response pulse / response data
//   SlvEn_S/SlvAddr_S        slave enable / slave byte address
//   SlvWrEn_S/SlvWr_D        slave byte write enables / write data
//   SlvRd_D                  slave read data
// -----------------------------------------------------------------------------
interface bram_dwc_seq_if #(
    parameter int ADDR_BITW     = 32,
    parameter int MST_DATA_BITW = 128,
    parameter int SLV_DATA_BITW = 32
);
    logic                         MstReq_S;
    logic                         MstGnt_S;
    logic [ADDR_BITW-1:0]         MstAddr_S;
    logic                         MstWe_S;
    logic [MST_DATA_BITW/8-1:0]   MstBe_S;
    logic [MST_DATA_BITW-1:0]     MstWr_D;
    logic                         MstRVal_S;
    logic [MST_DATA_BITW-1:0]     MstRd_D;
    logic                         SlvEn_S;
    logic [ADDR_BITW-1:0]         SlvAddr_S;
    logic [SLV_DATA_BITW/8-1:0]   SlvWrEn_S;
    logic [SLV_DATA_BITW-1:0]     SlvWr_D;
    logic [SLV_DATA_BITW-1:0]     SlvRd_D;

    modport slave (
        input  MstReq_S, MstAddr_S, MstWe_S, MstBe_S, MstWr_D, SlvRd_D,
        output MstGnt_S, MstRVal_S, MstRd_D, SlvEn_S, SlvAddr_S, SlvWrEn_S, SlvWr_D
    );

    modport master (
        output MstReq_S, MstAddr_S, MstWe_S, MstBe_S, MstWr_D, SlvRd_D,
        input  MstGnt_S, MstRVal_S, MstRd_D, SlvEn_S, SlvAddr_S, SlvWrEn_S, SlvWr_D
    );
endinterface

// File: rtl/bram_dwc_seq.sv
// -----------------------------------------------------------------------------
// bram_dwc_seq
// Sequential BRAM data width converter: a wide master access is split into
// RATIO = MST_DATA_BITW / SLV_DATA_BITW back-to-back narrow slave beats.
// Write beats with an all-zero byte-enable slice keep their cycle but do not
// enable the slave. Read beats are collected into one wide response word.
//
// Ports:
//   Clk_C   clock, rising edge
//   Rst_R   synchronous active-high reset
//   dwcBus  bram_dwc_seq_if.slave bundle (master channel + BRAM slave port)
//
// Timing: accept at T -> beats T+1..T+RATIO. Writes re-grant at T+RATIO+1,
// reads deliver MstRVal_S at T+RATIO+RD_LAT+1.
// -----------------------------------------------------------------------------
module bram_dwc_seq #(
    parameter int ADDR_BITW     = 32,
    parameter int MST_DATA_BITW = 128,
    parameter int SLV_DATA_BITW = 32,
    parameter int RD_LAT        = 1
) (
    input  logic              Clk_C,
    input  logic              Rst_R,
    bram_dwc_seq_if.slave     dwcBus
);

    // Width is a power-of-two number of whole bytes
    function automatic bit isPow2Bytes(input int bitw);
        return (bitw >= 8) && ((bitw % 8) == 0) && ((((bitw / 8) & ((bitw / 8) - 1))) == 0);
    endfunction

    localparam int RATIO         = MST_DATA_BITW / SLV_DATA_BITW;
    localparam int SLV_BYTEW     = SLV_DATA_BITW / 8;
    localparam int MST_BYTEW     = MST_DATA_BITW / 8;
    localparam int SLV_BYTE_OFFS = $clog2(SLV_BYTEW);
    localparam int CNT_BITW      = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [CNT_BITW-1:0]  CNT_ZERO   = {CNT_BITW{1'b0}};
    localparam logic [CNT_BITW-1:0]  CNT_ONE    = CNT_BITW'(1);
    localparam logic [CNT_BITW-1:0]  LAST_BEAT  = CNT_BITW'(RATIO - 1);
    // Clears the byte offset inside one wide word so beats start aligned
    localparam logic [ADDR_BITW-1:0] ALIGN_MASK = ~(ADDR_BITW'(MST_BYTEW - 1));

    // Elaboration-time parameter legality
    if ((MST_DATA_BITW % SLV_DATA_BITW) != 0) begin : g_badRatio
        $fatal(1, "bram_dwc_seq: MST_DATA_BITW must be a multiple of SLV_DATA_BITW");
    end
    if (!isPow2Bytes(MST_DATA_BITW) || !isPow2Bytes(SLV_DATA_BITW)) begin : g_badWidth
        $fatal(1, "bram_dwc_seq: data widths must be a power-of-two number of bytes");
    end
    if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_badLat
        $fatal(1, "bram_dwc_seq: RD_LAT must be 1 or 2");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        DRAIN = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t                     state_r;
    state_t                     stateNext_s;
    logic [CNT_BITW-1:0]        beatCnt_r;
    logic [CNT_BITW-1:0]        beatCntNext_s;
    logic [CNT_BITW-1:0]        capCnt_r;
    logic [ADDR_BITW-1:0]       baseAddr_r;
    logic [MST_BYTEW-1:0]       be_r;
    logic [MST_DATA_BITW-1:0]   wrData_r;
    logic [MST_DATA_BITW-1:0]   rdData_r;
    logic [MST_DATA_BITW-1:0]   rdDataNext_s;
    logic [MST_DATA_BITW-1:0]   mstRd_r;
    logic                       mstRVal_r;
    // Bit i set: a read beat was issued i+1 cycles ago
    logic [RD_LAT-1:0]          issuePipe_r;

    logic                       mstGnt_s;
    logic                       accept_s;
    logic                       issueNow_s;
    logic                       capFire_s;
    logic                       capLast_s;
    logic [SLV_BYTEW-1:0]       beSlice_s;
    logic [SLV_DATA_BITW-1:0]   dataSlice_s;
    logic [ADDR_BITW-1:0]       beatAddr_s;

    logic                       slvEn_s;
    logic [ADDR_BITW-1:0]       slvAddr_s;
    logic [SLV_BYTEW-1:0]       slvWrEn_s;
    logic [SLV_DATA_BITW-1:0]   slvWr_s;

    assign mstGnt_s    = (state_r == IDLE) && !Rst_R;
    assign accept_s    = dwcBus.MstReq_S && mstGnt_s;
    assign issueNow_s  = (state_r == RD);
    assign capFire_s   = issuePipe_r[RD_LAT-1];
    assign capLast_s   = capFire_s && (capCnt_r == LAST_BEAT);

    // Beat slices and address come only from latched request and beat counter
    assign beSlice_s   = be_r[beatCnt_r * SLV_BYTEW +: SLV_BYTEW];
    assign dataSlice_s = wrData_r[beatCnt_r * SLV_DATA_BITW +: SLV_DATA_BITW];
    assign beatAddr_s  = baseAddr_r + (ADDR_BITW'(beatCnt_r) << SLV_BYTE_OFFS);

    // Next-state and beat counter logic
    always_comb begin
        stateNext_s   = state_r;
        beatCntNext_s = beatCnt_r;
        case (state_r)
            IDLE: begin
                beatCntNext_s = CNT_ZERO;
                if (accept_s) begin
                    if (dwcBus.MstWe_S) begin
                        stateNext_s = WR;
                    end else begin
                        stateNext_s = RD;
                    end
                end else begin
                    stateNext_s = IDLE;
                end
            end
            WR: begin
                if (beatCnt_r == LAST_BEAT) begin
                    stateNext_s   = IDLE;
                    beatCntNext_s = CNT_ZERO;
                end else begin
                    beatCntNext_s = beatCnt_r + CNT_ONE;
                end
            end
            RD: begin
                if (beatCnt_r == LAST_BEAT) begin
                    stateNext_s   = DRAIN;
                    beatCntNext_s = CNT_ZERO;
                end else begin
                    beatCntNext_s = beatCnt_r + CNT_ONE;
                end
            end
            DRAIN: begin
                if (capLast_s) begin
                    stateNext_s = RESP;
                end else begin
                    stateNext_s = DRAIN;
                end
            end
            RESP: begin
                stateNext_s = IDLE;
            end
            default: begin
                stateNext_s   = IDLE;
                beatCntNext_s = CNT_ZERO;
            end
        endcase
    end

    // Slave port drive; idle and drain states leave the port quiet
    always_comb begin
        slvEn_s   = 1'b0;
        slvAddr_s = {ADDR_BITW{1'b0}};
        slvWrEn_s = {SLV_BYTEW{1'b0}};
        slvWr_s   = {SLV_DATA_BITW{1'b0}};
        case (state_r)
            WR: begin
                slvEn_s   = |beSlice_s;
                slvAddr_s = beatAddr_s;
                slvWrEn_s = beSlice_s;
                slvWr_s   = dataSlice_s;
            end
            RD: begin
                slvEn_s   = 1'b1;
                slvAddr_s = beatAddr_s;
            end
            default: begin
                slvEn_s   = 1'b0;
                slvAddr_s = {ADDR_BITW{1'b0}};
            end
        endcase
    end

    // Response word with the slice currently on SlvRd_D merged in
    always_comb begin
        rdDataNext_s = rdData_r;
        rdDataNext_s[capCnt_r * SLV_DATA_BITW +: SLV_DATA_BITW] = dwcBus.SlvRd_D;
    end

    // State register and beat counter
    always_ff @(posedge Clk_C) begin
        if (Rst_R) begin
            state_r   <= IDLE;
            beatCnt_r <= CNT_ZERO;
        end else begin
            state_r   <= stateNext_s;
            beatCnt_r <= beatCntNext_s;
        end
    end

    // Request latch, loaded only in the accept cycle
    always_ff @(posedge Clk_C) begin
        if (Rst_R) begin
            baseAddr_r <= {ADDR_BITW{1'b0}};
            be_r       <= {MST_BYTEW{1'b0}};
            wrData_r   <= {MST_DATA_BITW{1'b0}};
        end else if (accept_s) begin
            baseAddr_r <= dwcBus.MstAddr_S & ALIGN_MASK;
            be_r       <= dwcBus.MstBe_S;
            wrData_r   <= dwcBus.MstWr_D;
        end
    end

    // Read capture: slice k is taken exactly RD_LAT cycles after beat k
    always_ff @(posedge Clk_C) begin
        if (Rst_R) begin
            issuePipe_r <= {RD_LAT{1'b0}};
            capCnt_r    <= CNT_ZERO;
            rdData_r    <= {MST_DATA_BITW{1'b0}};
            mstRd_r     <= {MST_DATA_BITW{1'b0}};
            mstRVal_r   <= 1'b0;
        end else begin
            issuePipe_r <= RD_LAT'({issuePipe_r, issueNow_s});
            mstRVal_r   <= capLast_s;
            if (capFire_s) begin
                rdData_r <= rdDataNext_s;
                if (capLast_s) begin
                    capCnt_r <= CNT_ZERO;
                    mstRd_r  <= rdDataNext_s;
                end else begin
                    capCnt_r <= capCnt_r + CNT_ONE;
                end
            end
        end
    end

    assign dwcBus.MstGnt_S  = mstGnt_s;
    assign dwcBus.MstRVal_S = mstRVal_r;
    assign dwcBus.MstRd_D   = mstRd_r;
    assign dwcBus.SlvEn_S   = slvEn_s;
    assign dwcBus.SlvAddr_S = slvAddr_s;
    assign dwcBus.SlvWrEn_S = slvWrEn_s;
    assign dwcBus.SlvWr_D   = slvWr_s;

endmodule

// File: tb/tb_bram_dwc_seq.sv
// -----------------------------------------------------------------------------
// tb_bram_dwc_seq
// Directed bench for bram_dwc_seq. Three converters share one master stimulus:
//   dut1: 128->32, RD_LAT=1, behavioural BRAM
//   dut2: 128->32, RD_LAT=2, behavioural BRAM with two-stage read pipe
//   dut3: 32->32 (single beat), RD_LAT=1, read data = address ^ 0xCAFE0000
// Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_bram_dwc_seq;

    logic         clk;
    logic         rst;
    logic         mReq;
    logic [31:0]  mAddr;
    logic         mWe;
    logic [15:0]  mBe;
    logic [127:0] mWr;

    int nChecks;
    int nErrors;

    localparam logic [127:0] RD_EXP = 128'h000000A3_000000A2_000000A1_000000A0;

    bram_dwc_seq_if #(.ADDR_BITW(32), .MST_DATA_BITW(128), .SLV_DATA_BITW(32)) b1 ();
    bram_dwc_seq_if #(.ADDR_BITW(32), .MST_DATA_BITW(128), .SLV_DATA_BITW(32)) b2 ();
    bram_dwc_seq_if #(.ADDR_BITW(32), .MST_DATA_BITW(32),  .SLV_DATA_BITW(32)) b3 ();

    bram_dwc_seq #(.ADDR_BITW(32), .MST_DATA_BITW(128), .SLV_DATA_BITW(32), .RD_LAT(1))
        dut1 (.Clk_C(clk), .Rst_R(rst), .dwcBus(b1.slave));
    bram_dwc_seq #(.ADDR_BITW(32), .MST_DATA_BITW(128), .SLV_DATA_BITW(32), .RD_LAT(2))
        dut2 (.Clk_C(clk), .Rst_R(rst), .dwcBus(b2.slave));
    bram_dwc_seq #(.ADDR_BITW(32), .MST_DATA_BITW(32), .SLV_DATA_BITW(32), .RD_LAT(1))
        dut3 (.Clk_C(clk), .Rst_R(rst), .dwcBus(b3.slave));

    assign b1.MstReq_S = mReq;  assign b1.MstAddr_S = mAddr; assign b1.MstWe_S = mWe;
    assign b1.MstBe_S  = mBe;   assign b1.MstWr_D   = mWr;
    assign b2.MstReq_S = mReq;  assign b2.MstAddr_S = mAddr; assign b2.MstWe_S = mWe;
    assign b2.MstBe_S  = mBe;   assign b2.MstWr_D   = mWr;
    assign b3.MstReq_S = mReq;  assign b3.MstAddr_S = mAddr; assign b3.MstWe_S = mWe;
    assign b3.MstBe_S  = mBe[3:0];
    assign b3.MstWr_D  = mWr[31:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BRAMs
    logic [31:0] mem1 [0:1023];
    logic [31:0] mem2 [0:1023];
    logic [31:0] rdq1, rdq2a, rdq2b, rdq3;

    always_ff @(posedge clk) begin
        if (b1.SlvEn_S) begin
            for (int i = 0; i < 4; i++)
                if (b1.SlvWrEn_S[i]) mem1[b1.SlvAddr_S[11:2]][8*i +: 8] <= b1.SlvWr_D[8*i +: 8];
            rdq1 <= mem1[b1.SlvAddr_S[11:2]];
        end
    end

    always_ff @(posedge clk) begin
        if (b2.SlvEn_S) begin
            for (int j = 0; j < 4; j++)
                if (b2.SlvWrEn_S[j]) mem2[b2.SlvAddr_S[11:2]][8*j +: 8] <= b2.SlvWr_D[8*j +: 8];
            rdq2a <= mem2[b2.SlvAddr_S[11:2]];
        end
        rdq2b <= rdq2a;
    end

    always_ff @(posedge clk) begin
        if (b3.SlvEn_S) rdq3 <= b3.SlvAddr_S ^ 32'hCAFE0000;
    end

    assign b1.SlvRd_D = rdq1;
    assign b2.SlvRd_D = rdq2b;
    assign b3.SlvRd_D = rdq3;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic we, input logic [31:0] addr,
                           input logic [15:0] be, input logic [127:0] data);
        mReq  = 1'b1;
        mWe   = we;
        mAddr = addr;
        mBe   = be;
        mWr   = data;
    endtask

    initial begin
        int cyc;
        int lastAcc;
        int nAcc;
        int expGap;

        nChecks = 0;
        nErrors = 0;
        rst   = 1'b1;
        mReq  = 1'b0;
        mWe   = 1'b0;
        mAddr = 32'h0;
        mBe   = 16'h0;
        mWr   = 128'h0;

        // Reset state
        step();
        step();
        chk("rst_gnt",   b1.MstGnt_S,  1'b0);
        chk("rst_en",    b1.SlvEn_S,   1'b0);
        chk("rst_wren",  b1.SlvWrEn_S, 4'h0);
        chk("rst_addr",  b1.SlvAddr_S, 32'h0);
        chk("rst_wd",    b1.SlvWr_D,   32'h0);
        chk("rst_rval",  b1.MstRVal_S, 1'b0);
        chk("rst_rd",    b1.MstRd_D,   128'h0);
        rst = 1'b0;
        #1;
        chk("rst_gnt_after", b1.MstGnt_S, 1'b1);

        // Full write, 4 beats, plus the single-beat converter
        request(1'b1, 32'h100, 16'hFFFF, 128'h44444444_33333333_22222222_11111111);
        for (int b = 0; b < 4; b++) begin
            step();
            mReq = 1'b0;
            chk("wr_en",   b1.SlvEn_S,   1'b1);
            chk("wr_wren", b1.SlvWrEn_S, 4'hF);
            chk("wr_addr", b1.SlvAddr_S, 32'h100 + 32'(4 * b));
            chk("wr_data", b1.SlvWr_D,   32'h11111111 * 32'(b + 1));
            chk("wr_gnt_busy", b1.MstGnt_S, 1'b0);
            if (b == 0) begin
                chk("r1_wr_en",   b3.SlvEn_S,   1'b1);
                chk("r1_wr_addr", b3.SlvAddr_S, 32'h100);
                chk("r1_wr_data", b3.SlvWr_D,   32'h11111111);
            end else if (b == 1) begin
                chk("r1_wr_idle_en", b3.SlvEn_S,  1'b0);
                chk("r1_wr_gnt",     b3.MstGnt_S, 1'b1);
            end
        end
        step();
        chk("wr_gnt_t5", b1.MstGnt_S, 1'b1);

        // Partial write: only beat 1 enabled
        request(1'b1, 32'h200, 16'h00F0, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        for (int b = 0; b < 4; b++) begin
            step();
            mReq = 1'b0;
            chk("pw_en", b1.SlvEn_S, (b == 1) ? 1'b1 : 1'b0);
            if (b == 0) chk("r1_pw_suppressed", b3.SlvEn_S, 1'b0);
            if (b == 1) begin
                chk("pw_addr", b1.SlvAddr_S, 32'h204);
                chk("pw_wren", b1.SlvWrEn_S, 4'hF);
                chk("pw_data", b1.SlvWr_D,   32'hBBBBBBBB);
            end
        end
        step();
        chk("pw_gnt_t5", b1.MstGnt_S, 1'b1);

        // Preload 0x300..0x30C through the converters
        request(1'b1, 32'h300, 16'hFFFF, RD_EXP);
        step();
        mReq = 1'b0;
        for (int k = 0; k < 4; k++) step();

        // Unaligned read at 0x30C
        chk("rd_gnt_idle", b1.MstGnt_S & b2.MstGnt_S, 1'b1);
        request(1'b0, 32'h30C, 16'h0, 128'h0);
        for (int b = 0; b < 4; b++) begin
            step();
            mReq = 1'b0;
            chk("rd_en",   b1.SlvEn_S,   1'b1);
            chk("rd_wren", b1.SlvWrEn_S, 4'h0);
            chk("rd_addr", b1.SlvAddr_S, 32'h300 + 32'(4 * b));
            chk("rd_rval_early", b1.MstRVal_S, 1'b0);
            if (b == 0) chk("r1_rd_addr", b3.SlvAddr_S, 32'h30C);
            if (b == 1) chk("r1_rd_rval_early", b3.MstRVal_S, 1'b0);
            if (b == 2) begin
                chk("r1_rd_rval", b3.MstRVal_S, 1'b1);
                chk("r1_rd_data", b3.MstRd_D,   32'hCAFE030C);
            end
        end
        step();  // T+5
        chk("rd_drain_en", b1.SlvEn_S,   1'b0);
        chk("rd_rval_t5",  b1.MstRVal_S, 1'b0);
        chk("lat2_rval_t5", b2.MstRVal_S, 1'b0);
        step();  // T+6
        chk("rd_rval_t6",  b1.MstRVal_S, 1'b1);
        chk("rd_data",     b1.MstRd_D,   RD_EXP);
        chk("lat2_rval_t6", b2.MstRVal_S, 1'b0);
        step();  // T+7
        chk("rd_rval_t7",  b1.MstRVal_S, 1'b0);
        chk("rd_gnt_t7",   b1.MstGnt_S,  1'b1);
        chk("lat2_rval_t7", b2.MstRVal_S, 1'b1);
        chk("lat2_data",    b2.MstRd_D,   RD_EXP);
        step();
        chk("lat2_gnt_t8", b2.MstGnt_S, 1'b1);

        // Read data holds through a following write
        request(1'b1, 32'h400, 16'hFFFF, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321);
        for (int k = 0; k < 5; k++) begin
            step();
            mReq = 1'b0;
            chk("hold_rd1",   b1.MstRd_D,   RD_EXP);
            chk("hold_rd2",   b2.MstRd_D,   RD_EXP);
            chk("hold_rval1", b1.MstRVal_S, 1'b0);
        end

        // Request held high: alternating write/read stream on dut1
        request(1'b1, 32'h500, 16'hFFFF, 128'h0);
        cyc     = 0;
        lastAcc = 0;
        nAcc    = 0;
        expGap  = 0;
        while ((nAcc < 4) && (cyc < 60)) begin
            if (b1.MstGnt_S) begin
                if (nAcc > 0) chk("stream_gap", 128'(cyc - lastAcc), 128'(expGap));
                expGap  = mWe ? 5 : 7;
                lastAcc = cyc;
                nAcc++;
                step();
                cyc++;
                mWe   = ~mWe;
                mAddr = mWe ? 32'h500 : 32'h30C;
            end else begin
                step();
                cyc++;
            end
        end
        mReq = 1'b0;
        chk("stream_accepts", 128'(nAcc), 128'd4);
        for (int k = 0; k < 10; k++) step();
        chk("stream_rd_data", b1.MstRd_D, RD_EXP);

        // Reset pulse during a read after two beats
        request(1'b0, 32'h300, 16'h0, 128'h0);
        step();
        mReq = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("rst_mid_gnt", b1.MstGnt_S, 1'b0);
        step();
        rst = 1'b0;
        #1;
        chk("rst_mid_en",  b1.SlvEn_S,  1'b0);
        chk("rst_mid_gnt_after", b1.MstGnt_S, 1'b1);
        chk("rst_mid_rd",  b1.MstRd_D,  128'h0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rst_mid_rval", b1.MstRVal_S, 1'b0);
            chk("rst_mid_en_quiet", b1.SlvEn_S, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/bram_dwc_seq.md
Name: bram_dwc_seq

Overview:
Sequential BRAM data width converter that connects a wide master to a narrower BRAM slave port, MST_DATA_BITW = R * SLV_DATA_BITW with integer R >= 1. Each master access becomes R back-to-back slave beats. Write beats whose byte-enable slice is all zero are suppressed. Read beats are collected into one wide response. It sits between wide accelerator/DMA masters and existing narrow BRAM macros, and complements the combinational narrow-to-wide converter already in the BRAM library.

Parameters:
ADDR_BITW, 32, byte address width on both sides
MST_DATA_BITW, 128, master data width; multiple of SLV_DATA_BITW, power-of-two bytes
SLV_DATA_BITW, 32, slave BRAM data width; power-of-two bytes
RD_LAT, 1, slave read latency in cycles (1 or 2)

Ports:
Clk_C  in  1  clock; all logic on rising edge
Rst_R  in  1  synchronous, active-high reset
MstReq_S  in  1  master request valid
MstGnt_S  out  1  request accepted when MstReq_S & MstGnt_S
MstAddr_S  in  ADDR_BITW  master byte address
MstWe_S  in  1  1 = write, 0 = read
MstBe_S  in  MST_DATA_BITW/8  master byte enables
MstWr_D  in  MST_DATA_BITW  master write data
MstRVal_S  out  1  read response valid, one-cycle pulse
MstRd_D  out  MST_DATA_BITW  read response data
SlvEn_S  out  1  slave port enable
SlvAddr_S  out  ADDR_BITW  slave byte address
SlvWrEn_S  out  SLV_DATA_BITW/8  slave byte write enables
SlvWr_D  out  SLV_DATA_BITW  slave write data
SlvRd_D  in  SLV_DATA_BITW  slave read data, valid RD_LAT cycles after a read enable

Behaviour:
- Elaboration fatal if: MST % SLV != 0; either width is not a power-of-two number of bytes; RD_LAT not in {1,2}.
- R = MST/SLV. SLV_BYTEW = SLV_DATA_BITW/8. Beat counter width is max(1, log2 R).
- States: IDLE, WR, RD, DRAIN, RESP.
- Reset: state IDLE, counters 0. MstGnt_S=0 while Rst_R=1. SlvEn_S=0, SlvWrEn_S=0, SlvAddr_S=0, SlvWr_D=0. MstRVal_S=0, MstRd_D=0.
- IDLE: MstGnt_S=1 and no slave activity. On accept, the block latches the following:
  - the base address, with the low log2(MST_DATA_BITW/8) bits forced to 0;
  - MstWe_S, MstBe_S and MstWr_D.
  Beat counter b := 0. Next state is WR if MstWe_S=1, else RD.
- MstGnt_S=0 in every state other than IDLE. Master inputs are ignored outside the accept cycle.
- Beat mapping is little-endian: beat b uses data bits [b*SLV+SLV-1 : b*SLV] and BE bits [b*SLV_BYTEW +: SLV_BYTEW]. Its address is base + b*SLV_BYTEW, computed modulo 2^ADDR_BITW.
- WR: one beat per cycle, b = 0..R-1.
  - SlvEn_S = |BE slice; SlvWrEn_S = BE slice; SlvWr_D = data slice.
  - A beat with an all-zero BE slice still takes its cycle, so timing is fixed.
  - After beat R-1, go to IDLE. Accept at cycle T gives beats T+1..T+R and MstGnt_S=1 again at T+R+1.
- RD: SlvEn_S=1, SlvWrEn_S=0, one beat per cycle for b = 0..R-1, then go to DRAIN.
  - A separate capture counter stores SlvRd_D into slice k exactly RD_LAT cycles after beat k was issued.
- DRAIN: SlvEn_S=0. Wait until the last slice has been captured, then go to RESP.
- RESP: MstRVal_S=1 for one cycle with MstRd_D holding the full assembled word, then go to IDLE.
  - MstRd_D is a register and holds its value until the next response completes.
  - Read latency: accept at T, MstRVal_S at T+R+RD_LAT+1.
- R=1: single beat in both directions, same state flow and latency formula.
- Reset mid-operation: next cycle is IDLE and the transaction is aborted. No MstRVal_S, no further slave enables, partial captures discarded, MstRd_D cleared.
- Slave outputs are combinational from registered state, counter and latched request only. There is no path from Mst* inputs to Slv* outputs.

Test Plan:
- Write, R=4, addr 0x100, BE 0xFFFF, data 0x44444444_33333333_22222222_11111111, accept T -> SlvWrEn_S=0xF with addr/data 0x100/0x11111111, 0x104/0x22222222, 0x108/0x33333333, 0x10C/0x44444444 at T+1..T+4; MstGnt_S=1 at T+5.
- Partial write, BE 0x00F0, addr 0x200 -> SlvEn_S=1 only at T+2 (addr 0x204, WrEn 0xF); SlvEn_S=0 at T+1, T+3, T+4.
- Read, RD_LAT=1, BRAM 0x300..0x30C preloaded with 0xA0..0xA3, unaligned addr 0x30C -> beats at 0x300..0x30C; MstRVal_S only at T+6; MstRd_D=0x000000A3_000000A2_000000A1_000000A0.
- Same read with RD_LAT=2 -> MstRVal_S at T+7, same data. MstRd_D unchanged through a following write.
- MstReq_S held high for alternating write/read stream -> accepts only in IDLE: write re-accepts after 5 cycles, read after 7 (RD_LAT=1). No beat overlap.
- Rst_R pulsed for 1 cycle during RD after 2 beats -> SlvEn_S=0 next cycle, MstRVal_S never asserted, MstRd_D=0, MstGnt_S=1 on the cycle after reset deasserts.
